// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: load-use bubbles, branch flushes,
// multi-cycle mul/div freezes and data-memory wait states, plus a stall-cycle counter.
module pipeline_hazard_ctrl #(
  parameter int MULDIV_LAT  = 4,
  parameter int MEM_TIMEOUT = 64,
  parameter int CNT_W       = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             IDEX_MemRead_i,
  input  logic [4:0]       IDEX_Rt_i,
  input  logic [4:0]       IFID_Rs_i,
  input  logic [4:0]       IFID_Rt_i,
  input  logic             branch_taken_i,
  input  logic             muldiv_start_i,
  input  logic             mem_req_i,
  input  logic             mem_ack_i,
  output logic             PCWrite_o,
  output logic             IFIDWrite_o,
  output logic             IDEX_Bubble_o,
  output logic             IFID_Flush_o,
  output logic             Freeze_o,
  output logic             muldiv_done_o,
  output logic             mem_timeout_o,
  output logic [CNT_W-1:0] stall_cnt_o
);

  localparam int MD_W  = $clog2(MULDIV_LAT);
  localparam int TMO_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [MD_W-1:0]  MD_LOAD = MD_W'(MULDIV_LAT - 2);
  localparam logic [TMO_W-1:0] TMO_LIM = TMO_W'(MEM_TIMEOUT);

  typedef enum logic [1:0] {RUN, MD_WAIT, MEM_WAIT} state_t;

  state_t           state, state_nxt;
  logic [MD_W-1:0]  md_cnt;
  logic [TMO_W-1:0] tmo_cnt;
  logic             md_served;
  logic             mem_stall, md_trig, load_use;

  function automatic logic [CNT_W-1:0] sat_inc_stall(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  function automatic logic [TMO_W-1:0] sat_inc_tmo(input logic [TMO_W-1:0] v);
    return (v >= TMO_LIM) ? v : v + 1'b1;
  endfunction

  // Hazard detection; each term already excludes the higher-priority ones.
  assign mem_stall = (state == RUN) && mem_req_i && !mem_ack_i;
  assign md_trig   = (state == RUN) && muldiv_start_i && !md_served && !mem_stall;
  assign load_use  = (state == RUN) && !mem_stall && !md_trig && IDEX_MemRead_i &&
                     (IDEX_Rt_i != 5'd0) &&
                     ((IDEX_Rt_i == IFID_Rs_i) || (IDEX_Rt_i == IFID_Rt_i));

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) state <= RUN;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      RUN: begin
        if (mem_stall)    state_nxt = MEM_WAIT;
        else if (md_trig) state_nxt = MD_WAIT;
      end
      MD_WAIT:  if (md_cnt == '0) state_nxt = RUN;
      MEM_WAIT: if (mem_ack_i)    state_nxt = RUN;
      default:  state_nxt = RUN;
    endcase
  end

  always_comb begin
    PCWrite_o     = 1'b0;
    IFIDWrite_o   = 1'b0;
    IDEX_Bubble_o = 1'b0;
    IFID_Flush_o  = 1'b0;
    Freeze_o      = 1'b0;
    muldiv_done_o = 1'b0;
    if (rst_i) begin
      case (state)
        RUN: begin
          if (mem_stall || md_trig) begin
            Freeze_o = 1'b1;
          end else if (load_use) begin
            IDEX_Bubble_o = 1'b1;
          end else begin
            PCWrite_o    = 1'b1;
            IFIDWrite_o  = 1'b1;
            IFID_Flush_o = branch_taken_i;
          end
        end
        MD_WAIT: begin
          Freeze_o      = 1'b1;
          muldiv_done_o = (md_cnt == '0);
        end
        MEM_WAIT: begin
          Freeze_o    = !mem_ack_i;
          PCWrite_o   = mem_ack_i;
          IFIDWrite_o = mem_ack_i;
        end
        default: ;
      endcase
    end
  end

  // md_served keeps a still-asserted start from re-firing while the result leaves EX.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      md_cnt    <= '0;
      md_served <= 1'b0;
    end else begin
      if (md_trig)                                md_cnt <= MD_LOAD;
      else if (state == MD_WAIT && md_cnt != '0) md_cnt <= md_cnt - 1'b1;
      if (state == MD_WAIT && md_cnt == '0)       md_served <= 1'b1;
      else if (state == RUN && !Freeze_o)         md_served <= 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      tmo_cnt       <= '0;
      mem_timeout_o <= 1'b0;
    end else begin
      if (mem_stall) begin
        tmo_cnt <= '0;
      end else if (state == MEM_WAIT && !mem_ack_i) begin
        tmo_cnt <= sat_inc_tmo(tmo_cnt);
        if (sat_inc_tmo(tmo_cnt) >= TMO_LIM) mem_timeout_o <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i)          stall_cnt_o <= '0;
    else if (!PCWrite_o) stall_cnt_o <= sat_inc_stall(stall_cnt_o);
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: directed scenarios with literal expectations, then
// randomized traffic compared every cycle against a behavioural model.
module tb_pipeline_hazard_ctrl;

  localparam int LAT   = 4;
  localparam int TMO   = 2;
  localparam int CNT_W = 16;

  logic             clk_i = 1'b0;
  logic             rst_i;
  logic             IDEX_MemRead_i;
  logic [4:0]       IDEX_Rt_i, IFID_Rs_i, IFID_Rt_i;
  logic             branch_taken_i, muldiv_start_i, mem_req_i, mem_ack_i;
  logic             PCWrite_o, IFIDWrite_o, IDEX_Bubble_o, IFID_Flush_o;
  logic             Freeze_o, muldiv_done_o, mem_timeout_o;
  logic [CNT_W-1:0] stall_cnt_o;

  int n_vec = 0;
  int n_err = 0;

  pipeline_hazard_ctrl #(.MULDIV_LAT(LAT), .MEM_TIMEOUT(TMO), .CNT_W(CNT_W)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .IDEX_MemRead_i(IDEX_MemRead_i), .IDEX_Rt_i(IDEX_Rt_i),
    .IFID_Rs_i(IFID_Rs_i), .IFID_Rt_i(IFID_Rt_i),
    .branch_taken_i(branch_taken_i), .muldiv_start_i(muldiv_start_i),
    .mem_req_i(mem_req_i), .mem_ack_i(mem_ack_i),
    .PCWrite_o(PCWrite_o), .IFIDWrite_o(IFIDWrite_o),
    .IDEX_Bubble_o(IDEX_Bubble_o), .IFID_Flush_o(IFID_Flush_o),
    .Freeze_o(Freeze_o), .muldiv_done_o(muldiv_done_o),
    .mem_timeout_o(mem_timeout_o), .stall_cnt_o(stall_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d at t=%0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int m_md_left = 0;   // mul/div freeze cycles still owed after the current one
  bit m_in_mem  = 0;
  int m_waits   = 0;   // no-ack cycles seen since the memory stall began
  bit m_served  = 0;
  bit m_tmo     = 0;
  int m_stall   = 0;

  always @(negedge clk_i) begin
    logic e_pc, e_bub, e_fl, e_fz, e_done, lu;
    e_pc = 0; e_bub = 0; e_fl = 0; e_fz = 0; e_done = 0;
    if (!rst_i) begin
      m_md_left = 0; m_in_mem = 0; m_waits = 0; m_served = 0; m_tmo = 0; m_stall = 0;
    end else begin
      lu = IDEX_MemRead_i && IDEX_Rt_i != 0 &&
           (IDEX_Rt_i == IFID_Rs_i || IDEX_Rt_i == IFID_Rt_i);
      if (m_md_left > 0) begin
        e_fz = 1;
        e_done = (m_md_left == 1);
      end else if (m_in_mem) begin
        e_fz = !mem_ack_i;
        e_pc = mem_ack_i;
      end else if (mem_req_i && !mem_ack_i) begin
        e_fz = 1;
      end else if (muldiv_start_i && !m_served) begin
        e_fz = 1;
      end else if (lu) begin
        e_bub = 1;
      end else begin
        e_pc = 1;
        e_fl = branch_taken_i;
      end
    end
    chk("pcwrite",  32'(PCWrite_o),     32'(e_pc));
    chk("ifidwrite",32'(IFIDWrite_o),   32'(e_pc));
    chk("bubble",   32'(IDEX_Bubble_o), 32'(e_bub));
    chk("flush",    32'(IFID_Flush_o),  32'(e_fl));
    chk("freeze",   32'(Freeze_o),      32'(e_fz));
    chk("md_done",  32'(muldiv_done_o), 32'(e_done));
    chk("mem_tmo",  32'(mem_timeout_o), 32'(m_tmo));
    chk("stall_cnt",32'(stall_cnt_o),   32'(m_stall));
    if (rst_i) begin
      if (m_md_left > 0) begin
        m_md_left--;
        if (m_md_left == 0) m_served = 1;
      end else if (m_in_mem) begin
        if (mem_ack_i) m_in_mem = 0;
        else begin
          m_waits++;
          if (m_waits >= TMO) m_tmo = 1;
        end
      end else if (mem_req_i && !mem_ack_i) begin
        m_in_mem = 1;
        m_waits = 0;
      end else if (muldiv_start_i && !m_served) begin
        m_md_left = LAT - 1;
      end else begin
        m_served = 0;
      end
      if (!e_pc && m_stall < (1 << CNT_W) - 1) m_stall++;
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic setin(input logic mr, input logic [4:0] rt, input logic [4:0] rs,
                       input logic [4:0] irt, input logic br, input logic md,
                       input logic rq, input logic ak);
    IDEX_MemRead_i = mr; IDEX_Rt_i = rt; IFID_Rs_i = rs; IFID_Rt_i = irt;
    branch_taken_i = br; muldiv_start_i = md; mem_req_i = rq; mem_ack_i = ak;
  endtask

  task automatic apply_reset();
    tick();
    rst_i = 0;
    setin(0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    rst_i = 1;
  endtask

  initial begin
    rst_i = 0;
    setin(0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk_i);
    chk("rst_pc", 32'(PCWrite_o), 0);
    chk("rst_ifid", 32'(IFIDWrite_o), 0);
    chk("rst_stall", 32'(stall_cnt_o), 0);
    tick(); rst_i = 1;
    @(negedge clk_i); chk("run_pc", 32'(PCWrite_o), 1);

    // load-use, zero-register exemption, branch flush and its suppression
    tick(); setin(1, 8, 8, 0, 0, 0, 0, 0);
    @(negedge clk_i);
    chk("lu_pc", 32'(PCWrite_o), 0); chk("lu_ifid", 32'(IFIDWrite_o), 0);
    chk("lu_bub", 32'(IDEX_Bubble_o), 1);
    tick(); setin(0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk_i); chk("lu_stall", 32'(stall_cnt_o), 1); chk("lu_rel", 32'(PCWrite_o), 1);
    tick(); setin(1, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk_i); chk("r0_pc", 32'(PCWrite_o), 1); chk("r0_bub", 32'(IDEX_Bubble_o), 0);
    tick(); setin(0, 0, 0, 0, 1, 0, 0, 0);
    @(negedge clk_i); chk("br_flush", 32'(IFID_Flush_o), 1); chk("br_pc", 32'(PCWrite_o), 1);
    tick(); setin(1, 8, 3, 8, 1, 0, 0, 0);
    @(negedge clk_i); chk("brlu_flush", 32'(IFID_Flush_o), 0);
    chk("brlu_bub", 32'(IDEX_Bubble_o), 1);
    tick(); setin(0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk_i); chk("brlu_stall", 32'(stall_cnt_o), 2);

    // mul/div freeze of exactly LAT cycles, no re-trigger on release
    apply_reset();
    for (int i = 1; i <= LAT; i++) begin
      if (i > 1) tick();
      setin(0, 0, 0, 0, 0, 1, 0, 0);
      @(negedge clk_i);
      chk("md_fz", 32'(Freeze_o), 1);
      chk("md_done", 32'(muldiv_done_o), 32'(i == LAT));
    end
    tick();
    @(negedge clk_i);
    chk("md_rel_fz", 32'(Freeze_o), 0); chk("md_rel_pc", 32'(PCWrite_o), 1);
    chk("md_stall", 32'(stall_cnt_o), 4);
    tick(); setin(0, 0, 0, 0, 0, 0, 0, 0);

    // memory wait with sticky timeout
    apply_reset();
    for (int i = 1; i <= 3; i++) begin
      if (i > 1) tick();
      setin(0, 0, 0, 0, 0, 0, 1, 0);
      @(negedge clk_i);
      chk("mem_fz", 32'(Freeze_o), 1);
      if (i == 3) chk("mem_tmo_pre", 32'(mem_timeout_o), 0);
    end
    tick(); setin(0, 0, 0, 0, 0, 0, 1, 1);
    @(negedge clk_i);
    chk("mem_ack_fz", 32'(Freeze_o), 0); chk("mem_ack_pc", 32'(PCWrite_o), 1);
    chk("mem_tmo", 32'(mem_timeout_o), 1);
    tick(); setin(0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk_i); chk("mem_tmo_sticky", 32'(mem_timeout_o), 1);
    chk("mem_stall", 32'(stall_cnt_o), 3);

    // memory stall outranks mul/div; mul/div follows after the ack
    apply_reset();
    setin(0, 0, 0, 0, 0, 1, 1, 0);
    @(negedge clk_i); chk("sim_fz", 32'(Freeze_o), 1); chk("sim_done", 32'(muldiv_done_o), 0);
    tick(); setin(0, 0, 0, 0, 0, 1, 1, 1);
    @(negedge clk_i); chk("sim_ack_fz", 32'(Freeze_o), 0);
    for (int i = 1; i <= LAT; i++) begin
      tick(); setin(0, 0, 0, 0, 0, 1, 0, 0);
      @(negedge clk_i);
      chk("sim_md_fz", 32'(Freeze_o), 1);
      chk("sim_md_done", 32'(muldiv_done_o), 32'(i == LAT));
    end
    tick();
    @(negedge clk_i); chk("sim_rel_fz", 32'(Freeze_o), 0);
    chk("sim_stall", 32'(stall_cnt_o), 5);
    tick(); setin(0, 0, 0, 0, 0, 0, 0, 0);

    // reset asserted mid mul/div
    apply_reset();
    setin(0, 0, 0, 0, 0, 1, 0, 0);
    tick(); tick();
    rst_i = 0;
    #1;
    chk("mdrst_fz", 32'(Freeze_o), 0); chk("mdrst_pc", 32'(PCWrite_o), 0);
    chk("mdrst_done", 32'(muldiv_done_o), 0); chk("mdrst_stall", 32'(stall_cnt_o), 0);
    tick(); rst_i = 1; setin(0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk_i);
    chk("mdrst_run_fz", 32'(Freeze_o), 0); chk("mdrst_run_pc", 32'(PCWrite_o), 1);
    chk("mdrst_run_stall", 32'(stall_cnt_o), 0);

    // randomized traffic, checked by the model every cycle
    for (int n = 0; n < 3000; n++) begin
      tick();
      rst_i = ($urandom_range(0, 199) != 0);
      if ($urandom_range(0, 7) == 0) muldiv_start_i = ~muldiv_start_i;
      setin($urandom_range(0, 2) == 0, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
            5'($urandom_range(0, 3)), $urandom_range(0, 3) == 0, muldiv_start_i,
            $urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1);
    end
    @(negedge clk_i);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
Central stall/flush sequencer for the 5-stage pipeline. It sits beside the forwarding unit and covers the hazards forwarding cannot resolve: load-use stalls, taken-branch flushes, multi-cycle mul/div execution, and data-memory wait states. It drives PC/IF-ID write enables, bubble insertion, IF/ID flush and a global pipeline freeze, and keeps a saturating stall-cycle counter.

Parameters:
MULDIV_LAT, 4, total freeze cycles for a mul/div in EX; must be >= 2.
MEM_TIMEOUT, 64, MEM_WAIT cycles before mem_timeout_o sets.
CNT_W, 16, stall counter width.

Ports:
clk_i  in  1  clock; all state updates on rising edge
rst_i  in  1  asynchronous reset, active-low
IDEX_MemRead_i  in  1  instruction in EX is a load
IDEX_Rt_i  in  5  load destination register in EX
IFID_Rs_i  in  5  rs of instruction in ID
IFID_Rt_i  in  5  rt of instruction in ID
branch_taken_i  in  1  branch/jump in ID resolved taken
muldiv_start_i  in  1  mul/div in EX; level, held while instruction stays in EX
mem_req_i  in  1  load/store active in MEM
mem_ack_i  in  1  data memory completes access this cycle
PCWrite_o  out  1  1 = PC updates
IFIDWrite_o  out  1  1 = IF/ID latches
IDEX_Bubble_o  out  1  zero ID/EX control fields
IFID_Flush_o  out  1  clear IF/ID to nop
Freeze_o  out  1  hold ID/EX, EX/MEM and MEM/WB
muldiv_done_o  out  1  one-cycle pulse in final mul/div cycle
mem_timeout_o  out  1  sticky memory-timeout error
stall_cnt_o  out  CNT_W  cycles with PCWrite_o=0

Behaviour:
- While rst_i=0: state=RUN, counters 0, md_served=0, mem_timeout_o=0, stall_cnt_o=0. PCWrite_o=IFIDWrite_o=0. All other outputs 0. Reset asserted mid-stall aborts it immediately.
- Outputs are combinational from current state and inputs. State, counters and flags are registered.
- States: RUN, MD_WAIT, MEM_WAIT.
- Defaults (RUN, no hazard): PCWrite_o=IFIDWrite_o=1, others 0.
- Priority in RUN, highest first: mem stall, mul/div, load-use, branch flush.
- Mem stall:
  - Trigger: RUN with mem_req_i=1 and mem_ack_i=0.
  - Same cycle: Freeze_o=1, PCWrite_o=IFIDWrite_o=0. Next state MEM_WAIT, timeout counter cleared.
  - mem_req_i=1 with mem_ack_i=1 in RUN causes no stall.
- MEM_WAIT:
  - While mem_ack_i=0: Freeze_o=1, PCWrite_o=IFIDWrite_o=0, timeout counter +1 (saturating).
  - When the counter reaches MEM_TIMEOUT, mem_timeout_o sets and stays set until reset. The state stays MEM_WAIT.
  - On mem_ack_i=1: all freeze outputs release that cycle, next state RUN.
- Mul/div:
  - Trigger: RUN with muldiv_start_i=1, md_served=0, and no mem stall.
  - Same cycle: Freeze_o=1, PCWrite_o=IFIDWrite_o=0. cnt loads MULDIV_LAT-2, next state MD_WAIT.
- MD_WAIT:
  - Freeze_o=1, PCWrite_o=IFIDWrite_o=0, cnt decrements each cycle.
  - When cnt==0: muldiv_done_o=1, md_served set, next state RUN.
  - Total freeze is exactly MULDIV_LAT cycles, counting the trigger cycle.
  - md_served clears on the first RUN cycle with Freeze_o=0. This blocks a re-trigger while the finished instruction leaves EX.
- Load-use:
  - Condition: RUN, no freeze, IDEX_MemRead_i=1, IDEX_Rt_i!=0, and IDEX_Rt_i matches IFID_Rs_i or IFID_Rt_i.
  - Response: PCWrite_o=IFIDWrite_o=0, IDEX_Bubble_o=1, for one cycle. No state change.
- Branch flush:
  - Condition: RUN, branch_taken_i=1, no freeze, no load-use.
  - Response: IFID_Flush_o=1.
  - Suppressed during load-use or any freeze; the branch re-evaluates once released.
- IDEX_Bubble_o and IFID_Flush_o are never 1 while Freeze_o=1.
- stall_cnt_o increments every out-of-reset cycle with PCWrite_o=0. It saturates at all-ones.

Test Plan:
- Load-use: IDEX_MemRead_i=1, IDEX_Rt_i=8, IFID_Rs_i=8 -> one cycle of PCWrite_o=0, IFIDWrite_o=0, IDEX_Bubble_o=1; stall_cnt_o=1. Repeat with IDEX_Rt_i=0 -> no stall.
- Branch: branch_taken_i=1 with no hazard -> IFID_Flush_o=1 for one cycle. Same branch with a load-use match -> flush 0, bubble 1.
- Mul/div, MULDIV_LAT=4, muldiv_start_i held high until one cycle after muldiv_done_o:
  - Freeze_o=1 for exactly 4 cycles.
  - muldiv_done_o=1 in the 4th cycle only.
  - No re-trigger in the release cycle; stall_cnt_o=4.
- Mem wait: mem_req_i=1, mem_ack_i=0 for 3 cycles, then ack -> Freeze_o=1 for 3 cycles, released in the ack cycle. With MEM_TIMEOUT=2, mem_timeout_o=1 and stays 1 after the ack.
- Simultaneous: mem_req_i=1 (no ack) and muldiv_start_i=1 in the same cycle -> MEM_WAIT first; after ack, mul/div triggers and freezes 4 more cycles.
- Reset mid-MD_WAIT: drive rst_i=0 at cnt=1 -> outputs go to reset values immediately; after release the block is in RUN with stall_cnt_o=0.
